// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared widths, FSM state encoding and one-hot helper for the sequential 8-to-3 encoder
package enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc8to3.sv
// rtl/prio_enc8to3.sv - combinational rotating priority encoder, 8 request bits to a 3-bit index
//
// Purpose: returns the first set bit of req, searching upward from index base
//          and wrapping 7 -> 0. With base = 0 this is plain lowest-index-wins.
// Ports:
//   req   in  8  request vector
//   base  in  3  search start index
//   code  out 3  index of the first set bit at or after base (0 when none)
//   any   out 1  at least one request bit set
module prio_enc8to3
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    input  logic [CODE_W-1:0] base,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    logic [CODE_W-1:0] idx;

    // Walk from the farthest offset down to offset 0 so the last hit
    // written is the one closest to base; no early exit needed.
    always_comb begin
        code = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = base + CODE_W'(i);
            if (req[idx]) begin
                code = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder8to3_seq.sv
// rtl/encoder8to3_seq.sv - sequential 8-to-3 encoder: edge-captured requests served one code per handshake
//
// Purpose: synchronises 8 asynchronous request levels, turns each rising edge
//          into a sticky pending bit and hands pending indices to a consumer
//          over a valid/ready handshake, one code per accepted transfer.
// Build option: ENC_ROUND_ROBIN_EN - when defined, the encoder search starts
//          at a rotating pointer (one past the last accepted code) so no line
//          can starve; when undefined, lowest index always wins.
// Ports:
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   req_in     in   8  asynchronous request levels, one event per rising edge
//   out_code   out  3  index of the request being offered
//   out_valid  out  1  out_code is valid
//   out_ready  in   1  consumer accepts when out_valid && out_ready at clk edge
//   pending    out  8  captured events not yet accepted
//   drop       out  1  one-cycle pulse when a rise hits an already pending bit
module encoder8to3_seq
    import enc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_in,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_REQ-1:0]  pending,
    output logic              drop
);

    logic [N_REQ-1:0]  sync_q [SYNC_STAGES];
    logic [N_REQ-1:0]  req_s;
    logic [N_REQ-1:0]  req_q;
    logic [N_REQ-1:0]  rise;
    logic              acc;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  pend_nxt;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              valid_nxt;

    logic [N_REQ-1:0]  enc_req;
    logic [CODE_W-1:0] enc_base;
    logic [CODE_W-1:0] enc_code;
    logic              enc_any;

    // Synchroniser chain; req_q resets low so a line held high through
    // reset is seen as a rise once reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            req_q <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            req_q <= req_s;
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
    assign rise  = req_s & ~req_q;
    assign acc   = out_valid & out_ready;
    assign clr   = acc ? onehot(out_code) : '0;

    // A rise on the bit being accepted in the same cycle is ORed back in
    // after the clear, so that event survives as a fresh pending bit.
    assign pend_nxt = (pending & ~clr) | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            drop    <= 1'b0;
        end else begin
            pending <= pend_nxt;
            drop    <= |(rise & pending & ~clr);
        end
    end

    // In HOLD the next code is chosen from the post-accept set so transfers
    // can run back to back; in IDLE the registered set is enough.
    assign enc_req = (state == ST_HOLD) ? pend_nxt : pending;

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (acc) begin
            rr_ptr <= out_code + CODE_W'(1);
        end
    end

    // On an accept the pointer is moving this very edge, so search from
    // its new value rather than the stale register.
    assign enc_base = acc ? (out_code + CODE_W'(1)) : rr_ptr;
`else
    assign enc_base = '0;
`endif

    prio_enc8to3 u_prio (
        .req  (enc_req),
        .base (enc_base),
        .code (enc_code),
        .any  (enc_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_code  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_code  <= code_nxt;
            out_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = out_code;
        valid_nxt = out_valid;
        case (state)
            ST_IDLE: begin
                if (enc_any) begin
                    code_nxt  = enc_code;
                    valid_nxt = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (acc) begin
                    if (enc_any) begin
                        code_nxt = enc_code;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// tb/tb_encoder8to3_seq.sv - scoreboard bench for encoder8to3_seq with directed request vectors
module tb_encoder8to3_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       drop;

    int checks;
    int errors;
    int mon_checks;
    int mon_errors;

    logic [2:0] sb_q [$];

    encoder8to3_seq #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every accepted transfer pops the scoreboard; while held off
    // by backpressure the offered code and valid must not move.
    logic       prev_hold;
    logic [2:0] prev_code;
    logic [2:0] exp_code;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                mon_checks++;
                if (!out_valid || out_code !== prev_code) begin
                    mon_errors++;
                    $display("FAIL hold_stable: valid=%0b code=%0d required valid=1 code=%0d",
                             out_valid, out_code, prev_code);
                end
            end
            if (out_valid && out_ready) begin
                mon_checks++;
                if (sb_q.size() == 0) begin
                    mon_errors++;
                    $display("FAIL unexpected_code: got code=%0d with empty scoreboard", out_code);
                end else begin
                    exp_code = sb_q.pop_front();
                    if (out_code !== exp_code) begin
                        mon_errors++;
                        $display("FAIL code_order: got %0d required %0d", out_code, exp_code);
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_code = out_code;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(sb_q.size() == 0 && !out_valid && pending == 8'h00) && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: timeout with %0d codes outstanding, valid=%0b pending=%0h",
                     name, sb_q.size(), out_valid, pending);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        mon_checks = 0;
        mon_errors = 0;
        rst_n      = 1'b0;
        req_in     = 8'h00;
        out_ready  = 1'b0;
        tick(2);

        chk("rst_valid",   {7'd0, out_valid}, 8'h00);
        chk("rst_pending", pending,           8'h00);
        chk("rst_code",    {5'd0, out_code},  8'h00);
        chk("rst_drop",    {7'd0, drop},      8'h00);
        rst_n = 1'b1;

        // 1: reset in the middle of HOLD, then lines held high through reset
        req_in = 8'h0F;
        tick(5);
        chk("t1_pending_pre", pending,           8'h0F);
        chk("t1_valid_pre",   {7'd0, out_valid}, 8'h01);
        chk("t1_code_pre",    {5'd0, out_code},  8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid",   {7'd0, out_valid}, 8'h00);
        chk("t1_async_pending", pending,           8'h00);
        chk("t1_async_code",    {5'd0, out_code},  8'h00);
        tick(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd1);
        sb_q.push_back(3'd2);
        sb_q.push_back(3'd3);
        wait_drain("t1_held_high");
        req_in = 8'h00;
        tick(4);

        // 2: single request, latency SYNC_STAGES+2 edges, one-cycle code
        req_in = 8'h20;
        sb_q.push_back(3'd5);
        tick(3);
        chk("t2_valid_e3", {7'd0, out_valid}, 8'h00);
        tick(1);
        chk("t2_valid_e4", {7'd0, out_valid}, 8'h01);
        chk("t2_code_e4",  {5'd0, out_code},  8'h05);
        tick(1);
        chk("t2_valid_e5", {7'd0, out_valid}, 8'h00);
        chk("t2_pending",  pending,           8'h00);
        req_in = 8'h00;
        tick(4);

        // 3: backpressure, then back-to-back codes 0 and 7
        out_ready = 1'b0;
        req_in    = 8'h81;
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd7);
        tick(4);
        chk("t3_valid", {7'd0, out_valid}, 8'h01);
        chk("t3_code",  {5'd0, out_code},  8'h00);
        tick(4);
        chk("t3_code_held", {5'd0, out_code}, 8'h00);
        chk("t3_pending",   pending,          8'h81);
        out_ready = 1'b1;
        tick(1);
        chk("t3_code_next", {5'd0, out_code},  8'h07);
        chk("t3_valid_b2b", {7'd0, out_valid}, 8'h01);
        tick(1);
        chk("t3_valid_end", {7'd0, out_valid}, 8'h00);
        wait_drain("t3");
        req_in = 8'h00;
        tick(4);

        // 4: second rise on an already pending bit is dropped
        out_ready = 1'b0;
        req_in    = 8'h08;
        tick(4);
        chk("t4_code", {5'd0, out_code}, 8'h03);
        req_in = 8'h00;
        tick(4);
        req_in = 8'h08;
        tick(2);
        chk("t4_drop_before", {7'd0, drop}, 8'h00);
        tick(1);
        chk("t4_drop_pulse", {7'd0, drop}, 8'h01);
        tick(1);
        chk("t4_drop_after", {7'd0, drop}, 8'h00);
        sb_q.push_back(3'd3);
        out_ready = 1'b1;
        wait_drain("t4");
        req_in = 8'h00;
        tick(4);

        // 5: rise on bit 2 on the same edge that accepts code 2
        out_ready = 1'b0;
        req_in    = 8'h04;
        tick(4);
        chk("t5_code", {5'd0, out_code}, 8'h02);
        req_in = 8'h00;
        tick(4);
        req_in = 8'h04;
        tick(2);
        out_ready = 1'b1;
        sb_q.push_back(3'd2);
        sb_q.push_back(3'd2);
        tick(1);
        chk("t5_pending_kept", pending,           8'h04);
        chk("t5_valid_kept",   {7'd0, out_valid}, 8'h01);
        chk("t5_no_drop",      {7'd0, drop},      8'h00);
        wait_drain("t5");
        req_in = 8'h00;
        tick(4);

        // 6: all lines at once, then re-raise bits 0 and 7
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(3'(i));
        end
        req_in = 8'hFF;
        tick(3);
        chk("t6_pending_all", pending, 8'hFF);
        req_in = 8'h00;
        wait_drain("t6_all");
        tick(2);
        sb_q.push_back(3'd0);
        sb_q.push_back(3'd7);
        req_in = 8'h81;
        wait_drain("t6_reraise");
        req_in = 8'h00;
        tick(4);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d codes never seen, required 0", sb_q.size());
        end

        checks = checks + mon_checks;
        errors = errors + mon_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
